// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer, 32-entry register file and ALU.
// Latency: beq/j/illegal 3 cycles, R-type/addi/sw 4, lw 5, plus one cycle per memory wait cycle.
// Backpressure: holds mem_req/mem_we/mem_addr/mem_wdata steady in FETCH and MEM until mem_ready.
module mc_datapath #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter bit               SLT_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic             retire,
  output logic             illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;

  logic [WIDTH-1:0] rf_q [32];
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  logic             mem_req_raw;
  logic             retire_raw;
  logic             illegal_raw;

  // Instruction fields, always taken from the latched IR
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] imm_sext;
  logic             rtype_ok;
  logic             op_legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign rtype_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

  // Opcode legality; an unlisted R-type funct is treated like an unknown opcode
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE:                          op_legal = rtype_ok;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  // R-type ALU on the latched operands; slt result is a zero-extended single bit
  logic [WIDTH-1:0] alu_r;
  logic             slt_r;
  always_comb begin
    if (SLT_SIGNED) begin
      slt_r = $signed(a_q) < $signed(b_q);
    end else begin
      slt_r = a_q < b_q;
    end
    alu_r = '0;
    case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {{(WIDTH-1){1'b0}}, slt_r};
      default: alu_r = '0;
    endcase
  end

  // Sequencer: next state, datapath register updates, memory port and retire decode
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    rf_we       = 1'b0;
    rf_waddr    = rt;
    rf_wdata    = alu_q;
    mem_req_raw = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = b_q;
    retire_raw  = 1'b0;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          pc_d    = pc_q + WIDTH'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        // Branch target precomputed here from the already-incremented pc
        alu_d   = pc_q + (imm_sext << 2);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (!op_legal) begin
          retire_raw  = 1'b1;
          illegal_raw = 1'b1;
        end else begin
          case (opcode)
            OP_RTYPE: begin
              alu_d   = alu_r;
              state_d = S_WB;
            end
            OP_ADDI: begin
              alu_d   = a_q + imm_sext;
              state_d = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_d   = a_q + imm_sext;
              state_d = S_MEM;
            end
            OP_BEQ: begin
              if (a_q == b_q) begin
                pc_d = alu_q;
              end
              retire_raw = 1'b1;
            end
            OP_J: begin
              pc_d       = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
              retire_raw = 1'b1;
            end
            default: begin
              retire_raw = 1'b1;
            end
          endcase
        end
      end
      S_MEM: begin
        mem_req_raw = 1'b1;
        mem_addr    = alu_q;
        mem_we      = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire_raw = 1'b1;
            state_d    = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
        if (opcode == OP_RTYPE) begin
          rf_waddr = rd;
          rf_wdata = alu_q;
        end else if (opcode == OP_LW) begin
          rf_waddr = rt;
          rf_wdata = mdr_q;
        end else begin
          rf_waddr = rt;
          rf_wdata = alu_q;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset gating keeps the memory port and pulses quiet while reset is held
  assign mem_req = mem_req_raw & reset;
  assign retire  = retire_raw & reset;
  assign illegal = illegal_raw & reset;
  assign pc      = pc_q;

  // Sequencer state and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  // Register file write port; R0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: memory responder with programmable data wait states,
// store scoreboard, per-cycle retire/illegal/pc capture, table of ALU vectors.
module tb_mc_datapath;

  localparam int          W     = 32;
  localparam logic [31:0] RPC   = 32'h100;
  localparam bit          SLT_S = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ready;
  logic [W-1:0]  pc;
  logic          retire;
  logic          illegal;

  mc_datapath #(.WIDTH(W), .RESET_PC(RPC), .SLT_SIGNED(SLT_S)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory image, responder state and captured activity
  logic [31:0] mem [256];
  int          data_wait = 0;
  int          cyc = 0;
  logic [31:0] pc_at [64];
  int          retire_q[$];
  int          illegal_q[$];
  bit          in_acc;
  bit          is_data;
  int          waits_left;
  int          hold;
  int          first_data_hold;
  int          stable_err;
  logic [31:0] acc_addr;
  logic        acc_we;
  bit          first_seen;
  logic [31:0] first_addr;
  logic        first_we;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  st_t exp_q[$];
  st_t sb_e;

  task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic int ret_at(input int i);
    return (i < retire_q.size()) ? retire_q[i] : -1;
  endfunction

  function automatic int ill_at(input int i);
    return (i < illegal_q.size()) ? illegal_q[i] : -1;
  endfunction

  // Responder and monitor: decides mem_ready at the falling edge, samples outputs just after
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!reset) begin
        in_acc = 1'b0;
      end else begin
        cyc++;
        if (mem_req) begin
          is_data = (mem_addr != pc);
          if (!in_acc) begin
            in_acc     = 1'b1;
            waits_left = is_data ? data_wait : 0;
            hold       = 0;
            acc_addr   = mem_addr;
            acc_we     = mem_we;
            if (!first_seen) begin
              first_seen = 1'b1;
              first_addr = mem_addr;
              first_we   = mem_we;
            end
          end else if (mem_addr != acc_addr || mem_we != acc_we) begin
            stable_err++;
          end
          hold++;
          if (waits_left > 0) begin
            waits_left--;
          end else begin
            mem_ready = 1'b1;
            in_acc    = 1'b0;
            if (is_data && first_data_hold == 0) first_data_hold = hold;
            if (mem_we) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_store: addr 0x%08h data 0x%08h, none expected", mem_addr, mem_wdata);
              end else begin
                sb_e = exp_q.pop_front();
                chk("store_addr", mem_addr, sb_e.addr);
                chk("store_data", mem_wdata, sb_e.data);
              end
              mem[mem_addr[9:2]] = mem_wdata;
            end else begin
              mem_rdata = mem[mem_addr[9:2]];
            end
          end
        end else begin
          in_acc = 1'b0;
        end
        #1;
        if (cyc < 64) pc_at[cyc] = pc;
        if (retire) retire_q.push_back(cyc);
        if (illegal) illegal_q.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  function automatic logic [31:0] loopw();
    return itype(6'h04, 5'd0, 5'd0, 16'hFFFF);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // Program words live from RESET_PC (word index 64) upward
  task automatic put(input int k, input logic [31:0] w);
    mem[64 + k] = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_mem_req_now", {31'd0, mem_req}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc", pc, RPC);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    cyc = 0;
    retire_q.delete();
    illegal_q.delete();
    exp_q.delete();
    first_seen      = 1'b0;
    first_data_hold = 0;
    stable_err      = 0;
    in_acc          = 1'b0;
    for (int i = 0; i < 64; i++) pc_at[i] = '0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_to(input int t);
    int k = 0;
    while (cyc < t && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (cyc < t) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: reached cycle %0d, required %0d", cyc, t);
    end
    #2;
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_s;
    logic [31:0] exp_u;
    bit          ill;
  } vec_t;
  vec_t vt [9];

  initial begin
    reset = 1'b0;

    vt[0] = '{6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vt[1] = '{6'h20, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vt[2] = '{6'h22, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0};
    vt[3] = '{6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h00F0_1200, 1'b0};
    vt[4] = '{6'h25, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'hF000_000F, 1'b0};
    vt[5] = '{6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vt[6] = '{6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vt[7] = '{6'h2A, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[8] = '{6'h21, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b1};

    // addi/addi/add/sw with reset-release and retire-cadence checks
    clear_mem();
    put(0, itype(6'h08, 5'd0, 5'd1, 16'd5));
    put(1, itype(6'h08, 5'd0, 5'd2, 16'd7));
    put(2, rtype(5'd1, 5'd2, 5'd3, 6'h20));
    put(3, itype(6'h2B, 5'd0, 5'd3, 16'h0008));
    put(4, loopw());
    data_wait = 0;
    do_reset();
    expect_store(32'h8, 32'd12);
    run_to(17);
    chk("first_fetch_addr", first_addr, RPC);
    chk("first_fetch_we", {31'd0, first_we}, 32'd0);
    chk("pc_after_fetch", pc_at[2], 32'h104);
    chk("retire_addi1", ret_at(0), 32'd4);
    chk("retire_addi2", ret_at(1), 32'd8);
    chk("retire_add", ret_at(2), 32'd12);
    chk("retire_sw", ret_at(3), 32'd16);
    chk("seq_no_illegal", illegal_q.size(), 32'd0);
    chk("seq_store_seen", exp_q.size(), 32'd0);

    // lw with three wait cycles, then sw of the loaded value
    clear_mem();
    mem[2] = 32'h1234_5678;
    put(0, itype(6'h23, 5'd0, 5'd4, 16'h0008));
    put(1, itype(6'h2B, 5'd0, 5'd4, 16'h0020));
    put(2, loopw());
    data_wait = 3;
    do_reset();
    expect_store(32'h20, 32'h1234_5678);
    run_to(16);
    chk("lw_retire_cycle", ret_at(0), 32'd8);
    chk("sw_wait_retire_cycle", ret_at(1), 32'd15);
    chk("lw_req_hold", first_data_hold, 32'd4);
    chk("req_stable", stable_err, 32'd0);
    chk("lw_store_seen", exp_q.size(), 32'd0);
    data_wait = 0;

    // beq taken back onto itself
    clear_mem();
    put(0, itype(6'h04, 5'd1, 5'd1, 16'hFFFF));
    do_reset();
    run_to(4);
    chk("beq_t_retire", ret_at(0), 32'd3);
    chk("beq_t_pc_exec", pc_at[3], 32'h104);
    chk("beq_t_pc_after", pc_at[4], 32'h100);

    // beq not taken with unequal operands
    clear_mem();
    put(0, itype(6'h08, 5'd0, 5'd1, 16'd1));
    put(1, itype(6'h04, 5'd1, 5'd2, 16'h0004));
    put(2, loopw());
    do_reset();
    run_to(8);
    chk("beq_nt_retire", ret_at(1), 32'd7);
    chk("beq_nt_pc_after", pc_at[8], 32'h108);

    // j back to 0x100
    clear_mem();
    put(0, jtype(26'h40));
    do_reset();
    run_to(4);
    chk("j_retire", ret_at(0), 32'd3);
    chk("j_pc_after", pc_at[4], 32'h100);
    chk("j_no_illegal", illegal_q.size(), 32'd0);

    // writes to R0 are discarded
    clear_mem();
    put(0, itype(6'h08, 5'd0, 5'd0, 16'd9));
    put(1, itype(6'h2B, 5'd0, 5'd0, 16'h0030));
    put(2, loopw());
    do_reset();
    expect_store(32'h30, 32'd0);
    run_to(9);
    chk("r0_store_seen", exp_q.size(), 32'd0);

    // illegal opcode completes as a NOP
    clear_mem();
    put(0, itype(6'h08, 5'd0, 5'd1, 16'd5));
    put(1, 32'hFC21_0003);
    put(2, itype(6'h2B, 5'd0, 5'd1, 16'h0040));
    put(3, loopw());
    do_reset();
    expect_store(32'h40, 32'd5);
    run_to(12);
    chk("ill_count", illegal_q.size(), 32'd1);
    chk("ill_cycle", ill_at(0), 32'd7);
    chk("ill_retire_cycle", ret_at(1), 32'd7);
    chk("ill_store_seen", exp_q.size(), 32'd0);

    // ALU vectors: operands loaded from memory, result stored back
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      mem[32'h200 >> 2] = vt[i].a;
      mem[32'h204 >> 2] = vt[i].b;
      put(0, itype(6'h23, 5'd0, 5'd6, 16'h0200));
      put(1, itype(6'h23, 5'd0, 5'd7, 16'h0204));
      put(2, rtype(5'd6, 5'd7, 5'd5, vt[i].funct));
      put(3, itype(6'h2B, 5'd0, 5'd5, 16'h0208));
      put(4, loopw());
      do_reset();
      expect_store(32'h208, SLT_S ? vt[i].exp_s : vt[i].exp_u);
      run_to(20);
      chk($sformatf("alu_vec%0d_store_seen", i), exp_q.size(), 32'd0);
      chk($sformatf("alu_vec%0d_illegal", i), illegal_q.size(), {31'd0, vt[i].ill});
    end

    // reset asserted while sw waits in MEM: store must never complete
    clear_mem();
    put(0, itype(6'h08, 5'd0, 5'd1, 16'd5));
    put(1, itype(6'h2B, 5'd0, 5'd1, 16'h0050));
    put(2, loopw());
    data_wait = 20;
    do_reset();
    run_to(10);
    chk("abort_in_wait_req", {31'd0, mem_req}, 32'd1);
    chk("abort_in_wait_we", {31'd0, mem_we}, 32'd1);
    data_wait = 0;
    do_reset();
    chk("abort_no_store", mem[32'h50 >> 2], 32'd0);
    expect_store(32'h50, 32'd5);
    run_to(9);
    chk("abort_refetch_addr", first_addr, RPC);
    chk("abort_refetch_we", {31'd0, first_we}, 32'd0);
    chk("abort_rerun_store_seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
